matrix_stream_loader: RTL and testbench
=======================================

// Module: matrix_stream_loader
// PURPOSE
//  Upstream feeder for the combinational matrix multiplier.
//  Collects a serial valid/ready stream of 20-bit elements into register arrays A (A_ROW x A_COL) and B (B_ROW x B_COL).
//  Holds the arrays stable and flags them valid so the multiplier output can be sampled.
//  Releases them on a consumer acknowledge.
// PARAMETERS
//  DW     20  element width (multiplier product width = 2*DW)
//  A_ROW  5   rows of A
//  A_COL  3   cols of A; must equal B_ROW (elaboration $error otherwise)
//  B_ROW  3   rows of B
//  B_COL  6   cols of B
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  in_data     in   DW  element; A row-major first, then B row-major
//  in_valid    in   1   in_data valid
//  in_ready    out  1   loader can accept a beat
//  clear       in   1   sync abort of current load
//  a           out  DW  unpacked [0:A_ROW-1][0:A_COL-1], wires straight to multiplier .a
//  b           out  DW  unpacked [0:B_ROW-1][0:B_COL-1], wires straight to multiplier .b
//  mats_valid  out  1   a and b complete and stable
//  mats_taken  in   1   consumer done with a/b; honoured only while mats_valid=1
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all a/b elements 0, state LOAD_A, counters 0, mats_valid 0
//   - in_ready forced 0 while rst high
//  States: LOAD_A -> LOAD_B -> FULL -> LOAD_A
//  Beat: in_valid & in_ready at posedge.
//   - Writes in_data to current [row][col] of the active matrix.
//   - col increments; at col==last, col wraps to 0 and row increments.
//  LOAD_A: beat at a[A_ROW-1][A_COL-1] -> counters 0, next state LOAD_B.
//  LOAD_B: beat at b[B_ROW-1][B_COL-1] -> next state FULL.
//   - mats_valid=1 the cycle after that last beat (1-cycle latency).
//  FULL: in_ready=0, arrays frozen.
//   - mats_taken -> LOAD_A, mats_valid=0 next cycle.
//   - in_ready=1 from that cycle on.
//  in_ready = (state!=FULL) & !rst; combinational from registered state only (no in_valid path).
//  mats_taken outside FULL: ignored.
//  clear (priority over beat and mats_taken, any state):
//   - next state LOAD_A, counters 0, mats_valid 0
//   - array contents retained (stale, not zeroed)
//   - a beat in the same cycle is dropped
//  Array contents are never zeroed except by rst.
//   - A partially reloaded matrix may mix new and old elements.
//   - The consumer must gate on mats_valid.
//  in_valid gaps: no effect; counters advance only on beats.
//  Total beats per load: A_ROW*A_COL + B_ROW*B_COL (33 at defaults).
// STRUCTURE
//  Package mat_pkg: DW default, default dims, state typedef enum {LOAD_A, LOAD_B, FULL}.
//   - Shared with the multiplier bench.
//  Sub-module mat_idx_counter #(ROWS, COLS):
//   - row/col counter with inc, clr, and a last flag at [ROWS-1][COLS-1]
//   - one instance, re-limited per phase
//   - or two instances, A and B; implementer's choice, same behaviour
//  Top: FSM, write-enable decode into a/b, in_ready and mats_valid logic.
// TESTING (bench instantiates loader + MatrixMultiplier, checks mul)
//  1 Stream A=1000..15000 (step 1000), then B rows:
//     {111111..666666}, {777777,888888,999999,101010,111111,121212}, {131313..181818}
//    in_valid held high
//    -> mats_valid rises the cycle after beat 33
//    -> a[4][2]=15000, b[2][5]=181818, mul[0][0]=2060604000
//  2 Same data, in_valid asserted every other cycle
//    -> identical a/b/mul; mats_valid one cycle after beat 33
//  3 In FULL, offer a beat with in_valid=1
//    -> in_ready=0, arrays unchanged
//    Pulse mats_taken -> mats_valid=0, in_ready=1 next cycle
//    Next beat 7 lands in a[0][0]
//  4 Assert clear after 10 beats
//    -> mats_valid stays 0; next beat writes a[0][0]
//    -> full 33-beat reload completes normally
//  5 Assert rst after 20 beats
//    -> all a/b = 0 and mats_valid=0 immediately, in_ready=0 during rst
//    -> after release, loading restarts at a[0][0]
//  6 mats_taken pulsed during LOAD_B
//    -> ignored; load completes and mats_valid rises as normal

Source files
------------

// File: rtl/mat_pkg.sv
// Shared definitions for the matrix stream loader and the matrix multiplier bench:
// default element width, default matrix dimensions and the loader phase encoding.
package mat_pkg;

    localparam int unsigned MAT_DW    = 20;
    localparam int unsigned MAT_A_ROW = 5;
    localparam int unsigned MAT_A_COL = 3;
    localparam int unsigned MAT_B_ROW = 3;
    localparam int unsigned MAT_B_COL = 6;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        FULL   = 2'd2
    } load_state_e;

    // Index width that stays legal for a dimension of 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// Row-major [row][col] position counter. Wraps to [0][0] after the last element;
// last flags the final position so the caller can switch phase on that beat.
module mat_idx_counter
    import mat_pkg::*;
#(
    parameter int unsigned ROWS = MAT_A_ROW,
    parameter int unsigned COLS = MAT_A_COL
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inc,
    input  logic                        clr,
    output logic [idx_width(ROWS)-1:0]  row,
    output logic [idx_width(COLS)-1:0]  col,
    output logic                        last
);

    localparam int unsigned RW = idx_width(ROWS);
    localparam int unsigned CW = idx_width(COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/matrix_stream_loader.sv
// Collects a valid/ready element stream into matrices A then B, holds them stable with
// mats_valid until the consumer acknowledges with mats_taken, then starts the next load.
module matrix_stream_loader
    import mat_pkg::*;
#(
    parameter int unsigned DW    = MAT_DW,
    parameter int unsigned A_ROW = MAT_A_ROW,
    parameter int unsigned A_COL = MAT_A_COL,
    parameter int unsigned B_ROW = MAT_B_ROW,
    parameter int unsigned B_COL = MAT_B_COL
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          clear,
    output logic [DW-1:0] a [0:A_ROW-1][0:A_COL-1],
    output logic [DW-1:0] b [0:B_ROW-1][0:B_COL-1],
    output logic          mats_valid,
    input  logic          mats_taken
);

    if (A_COL != B_ROW) begin : g_bad_dims
        $error("matrix_stream_loader: A_COL (%0d) must equal B_ROW (%0d)", A_COL, B_ROW);
    end

    load_state_e state_q, state_d;
    logic        mats_valid_q, mats_valid_d;
    logic [DW-1:0] a_q [0:A_ROW-1][0:A_COL-1];
    logic [DW-1:0] a_d [0:A_ROW-1][0:A_COL-1];
    logic [DW-1:0] b_q [0:B_ROW-1][0:B_COL-1];
    logic [DW-1:0] b_d [0:B_ROW-1][0:B_COL-1];

    logic [idx_width(A_ROW)-1:0] a_row;
    logic [idx_width(A_COL)-1:0] a_col;
    logic [idx_width(B_ROW)-1:0] b_row;
    logic [idx_width(B_COL)-1:0] b_col;
    logic a_last, b_last;
    logic beat, wr_a, wr_b;

    assign in_ready = (state_q != FULL) & ~rst;
    assign beat     = in_valid & in_ready;
    // clear drops a coincident beat, so it must also gate the writes and counters.
    assign wr_a     = beat & ~clear & (state_q == LOAD_A);
    assign wr_b     = beat & ~clear & (state_q == LOAD_B);

    mat_idx_counter #(
        .ROWS (A_ROW),
        .COLS (A_COL)
    ) u_idx_a (
        .clk  (clk),
        .rst  (rst),
        .inc  (wr_a),
        .clr  (clear),
        .row  (a_row),
        .col  (a_col),
        .last (a_last)
    );

    mat_idx_counter #(
        .ROWS (B_ROW),
        .COLS (B_COL)
    ) u_idx_b (
        .clk  (clk),
        .rst  (rst),
        .inc  (wr_b),
        .clr  (clear),
        .row  (b_row),
        .col  (b_col),
        .last (b_last)
    );

    always_comb begin
        state_d      = state_q;
        mats_valid_d = mats_valid_q;
        a_d          = a_q;
        b_d          = b_q;
        if (wr_a) a_d[a_row][a_col] = in_data;
        if (wr_b) b_d[b_row][b_col] = in_data;
        if (clear) begin
            state_d      = LOAD_A;
            mats_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                LOAD_A: if (wr_a && a_last) state_d = LOAD_B;
                LOAD_B: begin
                    if (wr_b && b_last) begin
                        state_d      = FULL;
                        mats_valid_d = 1'b1;
                    end
                end
                FULL: begin
                    if (mats_taken) begin
                        state_d      = LOAD_A;
                        mats_valid_d = 1'b0;
                    end
                end
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD_A;
            mats_valid_q <= 1'b0;
            for (int i = 0; i < int'(A_ROW); i++)
                for (int j = 0; j < int'(A_COL); j++) a_q[i][j] <= '0;
            for (int i = 0; i < int'(B_ROW); i++)
                for (int j = 0; j < int'(B_COL); j++) b_q[i][j] <= '0;
        end else begin
            state_q      <= state_d;
            mats_valid_q <= mats_valid_d;
            a_q          <= a_d;
            b_q          <= b_d;
        end
    end

    assign a          = a_q;
    assign b          = b_q;
    assign mats_valid = mats_valid_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: directed scenarios plus random traffic, checked against
// a beat-index reference model and a reference matrix product.
module tb_matrix_stream_loader;
    import mat_pkg::*;

    localparam int unsigned DW = MAT_DW;
    localparam int AR = MAT_A_ROW;
    localparam int AC = MAT_A_COL;
    localparam int BR = MAT_B_ROW;
    localparam int BC = MAT_B_COL;
    localparam int NA = AR * AC;
    localparam int NT = NA + BR * BC;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          clear;
    logic [DW-1:0] a [0:AR-1][0:AC-1];
    logic [DW-1:0] b [0:BR-1][0:BC-1];
    logic          mats_valid;
    logic          mats_taken;

    always #5 clk = ~clk;

    matrix_stream_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .clear      (clear),
        .a          (a),
        .b          (b),
        .mats_valid (mats_valid),
        .mats_taken (mats_taken)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ref_a [0:AR-1][0:AC-1];
    logic [DW-1:0] ref_b [0:BR-1][0:BC-1];
    logic [DW-1:0] stim  [0:NT-1];
    int            m_k;
    bit            m_full;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < AR; i++) for (int j = 0; j < AC; j++) ref_a[i][j] = '0;
        for (int i = 0; i < BR; i++) for (int j = 0; j < BC; j++) ref_b[i][j] = '0;
        m_k    = 0;
        m_full = 1'b0;
    endtask

    // One clock: the model applies the stream rules by beat number, then the handshake
    // outputs are compared just after the edge.
    task automatic step();
        bit beat;
        beat = in_valid && !m_full && !rst && !clear;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (clear) begin
            m_k    = 0;
            m_full = 1'b0;
        end else if (m_full) begin
            if (mats_taken) m_full = 1'b0;
        end else if (beat) begin
            if (m_k < NA) ref_a[m_k / AC][m_k % AC] = in_data;
            else          ref_b[(m_k - NA) / BC][(m_k - NA) % BC] = in_data;
            m_k++;
            if (m_k == NT) begin
                m_k    = 0;
                m_full = 1'b1;
            end
        end
        #1;
        check_eq("mats_valid", 64'(mats_valid), 64'(m_full));
        check_eq("in_ready", 64'(in_ready), 64'(!m_full && !rst));
    endtask

    task automatic send(input logic [DW-1:0] d);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 50 && !acc; n++) begin
            acc = !m_full && !rst && !clear;
            step();
        end
        in_valid = 1'b0;
        check_eq("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic check_arrays(input string tag);
        for (int i = 0; i < AR; i++)
            for (int j = 0; j < AC; j++)
                check_eq($sformatf("%s a[%0d][%0d]", tag, i, j), 64'(a[i][j]), 64'(ref_a[i][j]));
        for (int i = 0; i < BR; i++)
            for (int j = 0; j < BC; j++)
                check_eq($sformatf("%s b[%0d][%0d]", tag, i, j), 64'(b[i][j]), 64'(ref_b[i][j]));
    endtask

    function automatic logic [2*DW-1:0] dut_mul(input int i, input int j);
        logic [2*DW-1:0] s = '0;
        for (int k = 0; k < AC; k++) s += (2*DW)'(a[i][k]) * (2*DW)'(b[k][j]);
        return s;
    endfunction

    task automatic check_mul(input string tag);
        logic [2*DW-1:0] exp;
        for (int i = 0; i < AR; i++)
            for (int j = 0; j < BC; j++) begin
                exp = '0;
                for (int k = 0; k < AC; k++) exp += (2*DW)'(ref_a[i][k]) * (2*DW)'(ref_b[k][j]);
                check_eq($sformatf("%s mul[%0d][%0d]", tag, i, j), 64'(dut_mul(i, j)), 64'(exp));
            end
    endtask

    task automatic take();
        mats_taken = 1'b1;
        step();
        mats_taken = 1'b0;
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send(DW'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        for (int k = 0; k < NA; k++) stim[k] = DW'((k + 1) * 1000);
        for (int c = 0; c < 6; c++) stim[NA + c] = DW'(111111 * (c + 1));
        for (int c = 0; c < 3; c++) stim[NA + 6 + c] = DW'(111111 * (c + 7));
        for (int c = 0; c < 3; c++) stim[NA + 9 + c] = DW'(10101 * (c + 10));
        for (int c = 0; c < 6; c++) stim[NA + 12 + c] = DW'(10101 * (c + 13));

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        clear      = 1'b0;
        mats_taken = 1'b0;
        model_reset();
        #1;
        check_eq("reset mats_valid", 64'(mats_valid), 64'd0);
        check_eq("reset in_ready", 64'(in_ready), 64'd0);
        check_arrays("reset");
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        rst      = 1'b0;

        // Directed load with in_valid held high.
        for (int k = 0; k < NT; k++) send(stim[k]);
        check_eq("t1 a[4][2]", 64'(a[4][2]), 64'd15000);
        check_eq("t1 b[2][5]", 64'(b[2][5]), 64'd181818);
        check_eq("t1 mul[0][0]", 64'(dut_mul(0, 0)), 64'd2060604000);
        check_arrays("t1");
        check_mul("t1");
        repeat (3) step();

        // Same data with a gap after every beat.
        take();
        for (int k = 0; k < NT; k++) begin
            send(stim[k]);
            step();
        end
        check_eq("t2 mul[0][0]", 64'(dut_mul(0, 0)), 64'd2060604000);
        check_arrays("t2");
        check_mul("t2");

        // Beat offered while FULL must be refused.
        in_valid = 1'b1;
        in_data  = DW'(12345);
        step();
        in_valid = 1'b0;
        check_arrays("t3 frozen");
        take();
        send(DW'(7));
        check_eq("t3 a[0][0]", 64'(a[0][0]), 64'd7);

        // clear after 10 beats (one already sent), with a coincident beat that is dropped.
        send_random(9);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check_arrays("t4 after clear");
        d = DW'($urandom);
        send(d);
        check_eq("t4 a[0][0]", 64'(a[0][0]), 64'(d));
        send_random(NT - 1);
        check_arrays("t4");
        check_mul("t4");

        // Reset mid-load.
        take();
        send_random(20);
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("t5 mats_valid", 64'(mats_valid), 64'd0);
        check_eq("t5 in_ready", 64'(in_ready), 64'd0);
        check_arrays("t5 rst");
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        rst      = 1'b0;
        d = DW'($urandom);
        send(d);
        check_eq("t5 a[0][0]", 64'(a[0][0]), 64'(d));
        send_random(NT - 1);
        check_arrays("t5");

        // mats_taken during LOAD_B is ignored.
        take();
        send_random(NA + 2);
        take();
        send_random(NT - NA - 2);
        check_arrays("t6");
        check_mul("t6");

        // Random traffic.
        for (int c = 0; c < 800; c++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            in_data    = DW'($urandom);
            mats_taken = ($urandom_range(0, 9) == 0);
            clear      = ($urandom_range(0, 59) == 0);
            step();
            if (c % 25 == 0) check_arrays("rand");
        end
        in_valid   = 1'b0;
        mats_taken = 1'b0;
        clear      = 1'b0;
        check_arrays("rand end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
